sw_debounce_reader: RTL and testbench

//   Input-side counterpart to the LED output path. Samples the board slide switches (SW) in the

---
 rtl/sw_debounce_reader.sv | 122 ++++++++++++
 tb/tb_sw_debounce_reader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce_reader.sv
// sw_debounce_reader
// Samples the board slide switches and passes each bit through a two-flop
// synchroniser and a per-bit debouncer. Every debounced change is reported as
// one snapshot event on a valid/ready port. If the consumer stalls, later
// changes are merged into the pending event, and a sticky overrun flag is set.
module sw_debounce_reader #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_state,
  output logic             event_valid,
  input  logic             event_ready,
  output logic [WIDTH-1:0] event_data,
  output logic [WIDTH-1:0] event_mask,
  output logic             overrun,
  input  logic             clear_overrun
);

  // Handshake: an event is transferred on every rising clock edge where
  // event_valid and event_ready are both 1. While event_valid is 1,
  // event_data and event_mask change only when a new change is merged into
  // the pending event. event_ready has no effect while event_valid is 0.

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_state;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic             r_ev_valid;
  logic [WIDTH-1:0] r_ev_data;
  logic [WIDTH-1:0] r_ev_mask;
  logic             r_overrun;

  logic [WIDTH-1:0] w_chg;
  logic [WIDTH-1:0] w_state_nxt;
  logic             w_change;
  logic             w_acc;

  // Two-flop synchroniser for the asynchronous switch levels.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= sw_in;
      r_s2 <= r_s1;
    end
  end

  // A bit flips on the cycle it has disagreed with sw_state for the full interval.
  always_comb begin
    w_chg = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_chg[i] = (r_s2[i] != r_state[i]) && (r_cnt[i] == CNT_LAST);
    end
  end

  assign w_state_nxt = r_state ^ w_chg;
  assign w_change    = |w_chg;
  assign w_acc       = r_ev_valid && event_ready;

  // Per-bit stability counters. A sample that matches the current level restarts the count.
  // The count returns to 0 on a flip, so it never passes CNT_LAST.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        if ((r_s2[i] == r_state[i]) || (r_cnt[i] == CNT_LAST)) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Event register. A change creates a fresh event when the slot is free or is
  // being accepted this cycle. Otherwise the change merges into the pending event.
  // A merge sets overrun, and a merge takes priority over clear_overrun.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ev_valid <= 1'b0;
      r_ev_data  <= '0;
      r_ev_mask  <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_change && (!r_ev_valid || w_acc)) begin
        r_ev_valid <= 1'b1;
        r_ev_data  <= w_state_nxt;
        r_ev_mask  <= w_chg;
      end else if (w_change) begin
        r_ev_data  <= w_state_nxt;
        r_ev_mask  <= r_ev_mask | w_chg;
      end else if (w_acc) begin
        r_ev_valid <= 1'b0;
      end

      if (w_change && r_ev_valid && !event_ready) begin
        r_overrun <= 1'b1;
      end else if (clear_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign sw_state    = r_state;
  assign event_valid = r_ev_valid;
  assign event_data  = r_ev_data;
  assign event_mask  = r_ev_mask;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_sw_debounce_reader.sv
// tb_sw_debounce_reader
// Directed scenarios followed by randomized switch and handshake traffic.
// All of it is compared each cycle against a reference model. The model
// describes debouncing as "the last DEBOUNCE_CYCLES synchronised samples all
// disagree with the current level".
module tb_sw_debounce_reader;

  localparam int W  = 10;
  localparam int DC = 4;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic [W-1:0] sw      = '0;
  logic         rdy     = 1'b0;
  logic         clr     = 1'b0;
  logic [W-1:0] o_state;
  logic         o_valid;
  logic [W-1:0] o_data;
  logic [W-1:0] o_mask;
  logic         o_ovr;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [W-1:0] m_s1, m_s2, m_state, m_data, m_mask;
  logic         m_valid, m_ovr;
  logic [W-1:0] m_hist [DC];

  sw_debounce_reader #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clock        (clk),
    .reset_n      (rst_n),
    .sw_in        (sw),
    .sw_state     (o_state),
    .event_valid  (o_valid),
    .event_ready  (rdy),
    .event_data   (o_data),
    .event_mask   (o_mask),
    .overrun      (o_ovr),
    .clear_overrun(clr)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_state = '0;
    m_data = '0; m_mask = '0; m_valid = 1'b0; m_ovr = 1'b0;
    for (int k = 0; k < DC; k++) m_hist[k] = '0;
  endtask

  // One rising edge of the model, using the inputs as they are driven now.
  task automatic model_edge();
    logic [W-1:0] flip;
    logic         acc;
    for (int k = DC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = m_s2;
    flip = '0;
    for (int i = 0; i < W; i++) begin
      flip[i] = 1'b1;
      for (int k = 0; k < DC; k++)
        if (m_hist[k][i] == m_state[i]) flip[i] = 1'b0;
    end
    acc = m_valid && rdy;
    if (flip != '0 && m_valid && !rdy) begin
      m_data = m_state ^ flip;
      m_mask = m_mask | flip;
      m_ovr  = 1'b1;
    end else begin
      if (flip != '0) begin
        m_valid = 1'b1;
        m_data  = m_state ^ flip;
        m_mask  = flip;
      end else if (acc) begin
        m_valid = 1'b0;
      end
      if (clr) m_ovr = 1'b0;
    end
    m_state = m_state ^ flip;
    m_s2 = m_s1;
    m_s1 = sw;
  endtask

  task automatic check_all();
    check("sw_state", o_state, m_state);
    check("event_valid", o_valid, m_valid);
    if (m_valid) begin
      check("event_data", o_data, m_data);
      check("event_mask", o_mask, m_mask);
    end
    check("overrun", o_ovr, m_ovr);
  endtask

  // Drive inputs at the falling edge, advance one clock, then check at the next falling edge.
  task automatic step(input logic [W-1:0] s, input logic r, input logic c, input logic rn);
    sw = s; rdy = r; clr = c; rst_n = rn;
    if (!rn) model_reset();
    @(posedge clk);
    if (rn) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic hold(input logic [W-1:0] s, input logic r, input int n);
    for (int k = 0; k < n; k++) step(s, r, 1'b0, 1'b1);
  endtask

  initial begin
    int ev_cnt;
    logic [W-1:0] cur;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_state", o_state, 0);
    check("reset_valid", o_valid, 0);
    check("reset_ovr", o_ovr, 0);

    // 1: first event lands on the sixth edge
    hold(10'h001, 1'b0, 5);
    check("t1_not_yet", o_valid, 0);
    step(10'h001, 1'b0, 1'b0, 1'b1);
    check("t1_valid", o_valid, 1);
    check("t1_state", o_state, 10'h001);
    check("t1_data", o_data, 10'h001);
    check("t1_mask", o_mask, 10'h001);
    check("t1_ovr", o_ovr, 0);

    // 3: coalesce while stalled, then clear overrun and accept
    hold(10'h021, 1'b0, 6);
    check("t3_data", o_data, 10'h021);
    check("t3_mask", o_mask, 10'h021);
    check("t3_ovr", o_ovr, 1);
    step(10'h021, 1'b0, 1'b1, 1'b1);
    check("t3_ovr_clr", o_ovr, 0);
    step(10'h021, 1'b1, 1'b0, 1'b1);
    check("t3_accepted", o_valid, 0);

    // 2: bounce on bit 3 yields exactly one event
    ev_cnt = 0;
    for (int k = 0; k < 14; k++) begin
      step((k >= 2 && k < 4) ? 10'h021 : 10'h029, 1'b1, 1'b0, 1'b1);
      if (o_valid) ev_cnt++;
    end
    check("t2_events", ev_cnt, 1);
    check("t2_state", o_state, 10'h029);

    // 4: two bits on one edge make one event
    step(10'h000, 1'b0, 1'b0, 1'b0);
    hold(10'h201, 1'b0, 6);
    check("t4_valid", o_valid, 1);
    check("t4_data", o_data, 10'h201);
    check("t4_mask", o_mask, 10'h201);

    // 5: accept on the same edge as a new flip
    hold(10'h211, 1'b0, 5);
    step(10'h211, 1'b1, 1'b0, 1'b1);
    check("t5_valid", o_valid, 1);
    check("t5_data", o_data, 10'h211);
    check("t5_mask", o_mask, 10'h010);
    check("t5_ovr", o_ovr, 0);
    step(10'h211, 1'b1, 1'b0, 1'b1);
    check("t5_accepted", o_valid, 0);

    // 6: reset mid-count and with an event pending
    hold(10'h3ff, 1'b0, 3);
    step(10'h3ff, 1'b0, 1'b0, 1'b0);
    check("t6_rst_state", o_state, 0);
    check("t6_rst_valid", o_valid, 0);
    hold(10'h3ff, 1'b0, 5);
    check("t6_restart", o_state, 0);
    step(10'h3ff, 1'b0, 1'b0, 1'b1);
    check("t6_state", o_state, 10'h3ff);
    check("t6_pending", o_valid, 1);
    step(10'h3ff, 1'b0, 1'b0, 1'b0);
    check("t6_lost_valid", o_valid, 0);
    check("t6_lost_state", o_state, 0);
    check("t6_lost_data", o_data, 0);
    check("t6_lost_mask", o_mask, 0);

    // random traffic: rare toggles, bursts of bounce, random ready/clear, rare resets
    cur = 10'h3ff;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 15) == 0) cur[i] = ~cur[i];
      step(cur, ($urandom_range(0, 99) < 35), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 599) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
